// File: rtl/alarm_pkg.sv
// Shared encodings and BCD helpers for the alarm clock controller.
// Alarm time is held as packed BCD: [7:4] tens digit, [3:0] units digit.
package alarm_pkg;

  typedef enum logic [1:0] {
    EDIT_IDLE  = 2'd0,
    EDIT_SET_H = 2'd1,
    EDIT_SET_M = 2'd2
  } edit_e;

  typedef enum logic {
    RING_OFF = 1'b0,
    RING_ON  = 1'b1
  } ring_e;

  localparam logic [7:0] HOUR_MAX = 8'h11;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // Increment a two-digit BCD value, wrapping to 00 after max_val.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
    logic [7:0] r;
    if (val == max_val) begin
      r = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      r = {val[7:4] + 4'd1, 4'd0};
    end else begin
      r = {val[7:4], val[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Raw button conditioning: 2-flop synchronizer, all-taps-agree debounce,
// and a single-cycle pulse on each debounced rising edge.
module btn_pulse #(
  parameter int DEB_TAPS = 7
) (
  input  logic kclk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [1:0]          sync_q;
  logic [DEB_TAPS-1:0] taps_q;
  logic                level_q;

  // level only moves when every tap agrees; mixed taps hold the old level
  always_ff @(posedge kclk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      taps_q  <= '0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      taps_q <= (taps_q << 1) | DEB_TAPS'(sync_q[1]);
      if (&taps_q) begin
        level_q <= 1'b1;
      end else if (~|taps_q) begin
        level_q <= 1'b0;
      end
      pulse <= (&taps_q) & ~level_q;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: button-driven alarm time editing plus a ring
// state machine that drives a square-wave buzzer on a time match.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int DEB_TAPS = 7,
  parameter int BEEP_CYC = 250,
  parameter int RING_CYC = 60000
) (
  input  logic       kclk,
  input  logic       rst,
  input  logic [3:0] h_1,
  input  logic [3:0] h_0,
  input  logic [3:0] m_1,
  input  logic [3:0] m_0,
  input  logic [3:0] s_1,
  input  logic [3:0] s_0,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_stop,
  input  logic       arm,
  output logic [3:0] ah_1,
  output logic [3:0] ah_0,
  output logic [3:0] am_1,
  output logic [3:0] am_0,
  output logic [1:0] edit,
  output logic       ringing,
  output logic       buzz
);

  localparam int RW = (RING_CYC > 1) ? $clog2(RING_CYC) : 1;
  localparam int BW = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_CYC - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);

  logic set_p, inc_p, stop_p;

  btn_pulse #(.DEB_TAPS(DEB_TAPS)) u_set  (.kclk(kclk), .rst(rst), .btn(btn_set),  .pulse(set_p));
  btn_pulse #(.DEB_TAPS(DEB_TAPS)) u_inc  (.kclk(kclk), .rst(rst), .btn(btn_inc),  .pulse(inc_p));
  btn_pulse #(.DEB_TAPS(DEB_TAPS)) u_stop (.kclk(kclk), .rst(rst), .btn(btn_stop), .pulse(stop_p));

  edit_e         edit_q, edit_d;
  ring_e         ring_q, ring_d;
  logic [7:0]    ah_q, ah_d, am_q, am_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          buzz_q, buzz_d;
  logic          match, match_q, trigger, ring_busy;

  // Digit-wise compare; out-of-range input digits can never equal the alarm digits.
  assign match   = ({h_1, h_0} == ah_q) && ({m_1, m_0} == am_q) &&
                   (s_1 == 4'd0) && (s_0 == 4'd0);
  assign trigger = match && !match_q && arm && (edit_q == EDIT_IDLE);

  always_ff @(posedge kclk or posedge rst) begin
    if (rst) begin
      edit_q     <= EDIT_IDLE;
      ring_q     <= RING_OFF;
      ah_q       <= 8'h00;
      am_q       <= 8'h00;
      ring_cnt_q <= '0;
      beep_cnt_q <= '0;
      buzz_q     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      edit_q     <= edit_d;
      ring_q     <= ring_d;
      ah_q       <= ah_d;
      am_q       <= am_d;
      ring_cnt_q <= ring_cnt_d;
      beep_cnt_q <= beep_cnt_d;
      buzz_q     <= buzz_d;
      match_q    <= match;
    end
  end

  // Ring FSM: a stop pulse coincident with a trigger keeps it OFF.
  always_comb begin
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    beep_cnt_d = beep_cnt_q;
    buzz_d     = buzz_q;
    case (ring_q)
      RING_OFF: begin
        buzz_d = 1'b0;
        if (trigger && !stop_p) begin
          ring_d     = RING_ON;
          ring_cnt_d = '0;
          beep_cnt_d = '0;
          buzz_d     = 1'b1;
        end
      end
      RING_ON: begin
        if (stop_p || !arm || (ring_cnt_q == RING_LAST)) begin
          ring_d     = RING_OFF;
          ring_cnt_d = '0;
          beep_cnt_d = '0;
          buzz_d     = 1'b0;
        end else begin
          ring_cnt_d = ring_cnt_q + RW'(1);
          if (beep_cnt_q == BEEP_LAST) begin
            beep_cnt_d = '0;
            buzz_d     = ~buzz_q;
          end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end
      end
    endcase
  end

  // Buttons are dead while ringing, including the cycle the ring starts.
  assign ring_busy = (ring_q == RING_ON) || (ring_d == RING_ON);

  always_comb begin
    edit_d = edit_q;
    ah_d   = ah_q;
    am_d   = am_q;
    if (!ring_busy) begin
      case (edit_q)
        EDIT_IDLE: begin
          if (set_p) edit_d = EDIT_SET_H;
        end
        EDIT_SET_H: begin
          if (set_p)      edit_d = EDIT_SET_M;
          else if (inc_p) ah_d   = bcd_inc(ah_q, HOUR_MAX);
        end
        EDIT_SET_M: begin
          if (set_p)      edit_d = EDIT_IDLE;
          else if (inc_p) am_d   = bcd_inc(am_q, MIN_MAX);
        end
        default: edit_d = EDIT_IDLE;
      endcase
    end
  end

  assign ah_1    = ah_q[7:4];
  assign ah_0    = ah_q[3:0];
  assign am_1    = am_q[7:4];
  assign am_0    = am_q[3:0];
  assign edit    = edit_q;
  assign ringing = (ring_q == RING_ON);
  assign buzz    = buzz_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed edit/ring scenarios plus random button
// presses scored against an integer model of the alarm time and edit mode.
module tb_alarm_ctrl;

  localparam int DEB_TAPS = 7;
  localparam int BEEP_CYC = 250;
  localparam int RING_CYC = 60000;

  logic       kclk = 1'b0;
  logic       rst;
  logic [3:0] h_1, h_0, m_1, m_0, s_1, s_0;
  logic       btn_set, btn_inc, btn_stop, arm;
  logic [3:0] ah_1, ah_0, am_1, am_0;
  logic [1:0] edit;
  logic       ringing, buzz;

  int checks = 0;
  int errors = 0;

  // model state
  int m_edit = 0;
  int m_hour = 0;
  int m_min  = 0;
  bit m_ring = 0;
  logic [15:0] exp_q[$];

  alarm_ctrl #(.DEB_TAPS(DEB_TAPS), .BEEP_CYC(BEEP_CYC), .RING_CYC(RING_CYC)) dut (
    .kclk(kclk), .rst(rst),
    .h_1(h_1), .h_0(h_0), .m_1(m_1), .m_0(m_0), .s_1(s_1), .s_0(s_0),
    .btn_set(btn_set), .btn_inc(btn_inc), .btn_stop(btn_stop), .arm(arm),
    .ah_1(ah_1), .ah_0(ah_0), .am_1(am_1), .am_0(am_0),
    .edit(edit), .ringing(ringing), .buzz(buzz)
  );

  // clock / reset
  always #5 kclk = ~kclk;

  task automatic tick(input int n);
    repeat (n) @(posedge kclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [15:0] model_alarm();
    return {to_bcd(m_hour), to_bcd(m_min)};
  endfunction

  task automatic set_time(input int hh, input int mm, input int ss);
    {h_1, h_0} = to_bcd(hh);
    {m_1, m_0} = to_bcd(mm);
    {s_1, s_0} = to_bcd(ss);
  endtask

  // driver: which 0=set 1=inc; a pulse exists only if held for DEB_TAPS samples
  task automatic press(input int which, input int hold);
    if (which == 0) btn_set = 1'b1; else btn_inc = 1'b1;
    tick(hold);
    btn_set = 1'b0;
    btn_inc = 1'b0;
    tick(14);
    if (hold >= DEB_TAPS && !m_ring) begin
      if (which == 0) begin
        m_edit = (m_edit + 1) % 3;
      end else if (m_edit == 1) begin
        m_hour = (m_hour + 1) % 12;
      end else if (m_edit == 2) begin
        m_min = (m_min + 1) % 60;
      end
    end
  endtask

  task automatic edit_to(input int hh, input int mm);
    press(0, 12);
    while (m_hour != hh) press(1, 12);
    press(0, 12);
    while (m_min != mm) press(1, 12);
    press(0, 12);
    check("edit_to_mode", edit, 0);
    check("edit_to_alarm", {ah_1, ah_0, am_1, am_0}, model_alarm());
  endtask

  task automatic trigger_ring();
    set_time(1, 4, 59);
    tick(3);
    check("pre_match", ringing, 0);
    set_time(1, 5, 0);
    tick(1);
    check("trig_ring", ringing, 1);
    m_ring = 1;
  endtask

  int  ring_len;
  int  buzz_bad;
  logic exp_b;

  initial begin
    rst = 1'b1;
    btn_set = 0; btn_inc = 0; btn_stop = 0; arm = 0;
    set_time(12, 34, 56);
    #3;
    check("rst_alarm", {ah_1, ah_0, am_1, am_0}, 16'h0000);
    check("rst_edit", edit, 0);
    check("rst_ring", {ringing, buzz}, 2'b00);
    tick(3);
    rst = 1'b0;
    tick(3);

    // latency: pulse 10 cycles after press, mode moves on the next edge
    btn_set = 1'b1;
    tick(10);
    check("lat_before", edit, 0);
    tick(1);
    check("lat_after", edit, 1);
    tick(1);
    btn_set = 1'b0;
    tick(14);
    m_edit = 1;

    // set, inc x3, set, inc x12, set -> 03:12
    repeat (3) press(1, 12);
    press(0, 12);
    check("seq_set_m", edit, 2);
    repeat (12) press(1, 12);
    press(0, 12);
    check("seq_idle", edit, 0);
    check("seq_alarm", {ah_1, ah_0, am_1, am_0}, 16'h0312);
    press(1, 12);
    check("idle_inc", {ah_1, ah_0, am_1, am_0}, 16'h0312);

    // wraps
    press(0, 12);
    while (m_hour != 11) press(1, 12);
    check("hour_11", {ah_1, ah_0}, 8'h11);
    press(1, 12);
    check("hour_wrap", {ah_1, ah_0}, 8'h00);
    press(1, 3);
    check("glitch", {ah_1, ah_0}, 8'h00);
    press(0, 12);
    while (m_min != 59) press(1, 12);
    check("min_59", {am_1, am_0}, 8'h59);
    press(1, 12);
    check("min_wrap", {ah_1, ah_0, am_1, am_0}, 16'h0000);
    press(0, 12);
    check("wrap_idle", edit, 0);

    // full ring at 01:05
    edit_to(1, 5);
    arm = 1'b1;
    trigger_ring();
    ring_len = 0;
    buzz_bad = 0;
    while (ringing === 1'b1 && ring_len < RING_CYC + 100) begin
      exp_b = ((ring_len / BEEP_CYC) % 2) == 0;
      if (buzz !== exp_b) buzz_bad++;
      ring_len++;
      tick(1);
    end
    m_ring = 0;
    check("ring_len", ring_len, RING_CYC);
    check("buzz_wave", buzz_bad, 0);
    check("buzz_off", buzz, 0);
    tick(50);
    check("no_retrig", ringing, 0);

    // disarmed at match, then re-armed while match persists
    set_time(1, 4, 59);
    tick(2);
    arm = 1'b0;
    set_time(1, 5, 0);
    tick(5);
    check("disarmed", ringing, 0);
    arm = 1'b1;
    tick(5);
    check("rearm_hold", ringing, 0);

    // stop button
    trigger_ring();
    tick(20);
    btn_stop = 1'b1;
    tick(10);
    check("stop_lat", ringing, 1);
    tick(1);
    check("stop_ring", {ringing, buzz}, 2'b00);
    tick(2);
    btn_stop = 1'b0;
    tick(14);
    m_ring = 0;

    // buttons ignored while ringing; arm drop ends the ring
    trigger_ring();
    press(0, 12);
    check("ring_set", edit, 0);
    press(1, 12);
    check("ring_inc", {ah_1, ah_0, am_1, am_0}, 16'h0105);
    arm = 1'b0;
    tick(1);
    check("arm_drop", {ringing, buzz}, 2'b00);
    m_ring = 0;
    arm = 1'b1;

    // trigger and stop pulse in the same cycle
    set_time(1, 4, 59);
    tick(3);
    btn_stop = 1'b1;
    tick(10);
    set_time(1, 5, 0);
    tick(1);
    check("trig_stop", ringing, 0);
    tick(3);
    btn_stop = 1'b0;
    tick(14);
    check("trig_stop_hold", ringing, 0);

    // async reset mid-ring
    trigger_ring();
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_ring", {ringing, buzz}, 2'b00);
    check("rst_mid_alarm", {ah_1, ah_0, am_1, am_0}, 16'h0000);
    tick(2);
    rst = 1'b0;
    m_edit = 0; m_hour = 0; m_min = 0; m_ring = 0;
    tick(2);

    // button held across reset release
    btn_set = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(12);
    check("held_rst", edit, 1);
    btn_set = 1'b0;
    tick(14);
    m_edit = 1;

    // random presses scored against the model
    set_time(12, 34, 56);
    for (int i = 0; i < 40; i++) begin
      press($urandom_range(0, 1), $urandom_range(3, 20));
      exp_q.push_back(model_alarm());
      check("rnd_edit", edit, m_edit);
      check("rnd_alarm", {ah_1, ah_0, am_1, am_0}, exp_q.pop_front());
    end
    check("rnd_ring", ringing, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter DEB_TAPS, default 7: consecutive equal kclk samples for a valid button level.
REQ-002 SHALL have parameter BEEP_CYC, default 250: buzz half-period in kclk cycles.
REQ-003 SHALL have parameter RING_CYC, default 60000: maximum ring duration in kclk cycles.
REQ-004 SHALL have ports, in this order:
  kclk  in  1  1 kHz system clock
  rst  in  1  reset, asynchronous, active-high
  h_1,h_0,m_1,m_0,s_1,s_0  in  4 each  running time digits, BCD
  btn_set  in  1  raw button: cycles the edit mode
  btn_inc  in  1  raw button: increments the edited field
  btn_stop  in  1  raw button: silences the alarm
  arm  in  1  level switch: alarm enabled
  ah_1,ah_0,am_1,am_0  out  4 each  alarm time digits, BCD, registered
  edit  out  2  0=IDLE, 1=SET_H, 2=SET_M
  ringing  out  1  alarm active
  buzz  out  1  square-wave buzzer drive

Function
REQ-005 Each raw button SHALL pass through a 2-flop synchronizer, then a DEB_TAPS shift register; the debounced level SHALL change only when all taps agree.
REQ-006 A 1-cycle pulse SHALL be produced on each debounced 0->1 transition; holding a button SHALL yield exactly one pulse.
REQ-007 Press-to-pulse latency SHALL be 2 + DEB_TAPS + 1 kclk cycles (10 with the default).
REQ-008 Edit FSM: IDLE -set-> SET_H -set-> SET_M -set-> IDLE; other inputs SHALL not change state.
REQ-009 In SET_H, an inc pulse SHALL advance the alarm hour 00..11 and wrap 11->00.
REQ-010 In SET_M, an inc pulse SHALL advance the alarm minute 00..59 and wrap 59->00; it SHALL not carry into hours.
REQ-011 BCD rule: when a units digit is 9, it SHALL go to 0 and the tens digit SHALL increment; all digits SHALL stay 0..9.
REQ-012 inc pulses in IDLE SHALL be ignored.
REQ-013 Match SHALL be true when h,m equal ah,am, s_1 = 0 and s_0 = 0, with digit-wise compare.
REQ-014 A trigger SHALL be the rising edge of match, using the registered previous match value.
REQ-015 A trigger SHALL act only when arm = 1 and edit = IDLE.
REQ-016 Ring FSM: OFF -trigger-> RING.
REQ-017 RING -> OFF SHALL occur on a stop pulse, on arm = 0, or when the ring counter reaches RING_CYC-1.
REQ-018 ringing SHALL be 1 exactly in RING, starting the cycle after the trigger.
REQ-019 While in RING, buzz SHALL toggle every BEEP_CYC cycles, starting at 1.
REQ-020 buzz SHALL be 0 in OFF.
REQ-021 The ring and beep counters SHALL clear on entry to RING.
REQ-022 While in RING, set and inc pulses SHALL be ignored, so edit holds IDLE.
REQ-023 On a same-cycle trigger and stop pulse, the FSM SHALL stay OFF.
REQ-024 A match that persists after the alarm ends SHALL NOT retrigger; a new trigger SHALL need match to fall and rise again.
REQ-025 Changing the alarm time while in IDLE is impossible, so no mid-match edits SHALL occur.
REQ-026 Input digits above 9 SHALL simply not match.

Reset
REQ-027 On rst = 1, asynchronously: ah/am = 00:00, edit = IDLE, ring = OFF, ringing = 0, buzz = 0.
REQ-028 On rst = 1, all counters, synchronizer and debounce taps, and the previous-match flag SHALL be 0.
REQ-029 Reset during RING SHALL silence the alarm immediately, without waiting for a clock edge.
REQ-030 A button held across reset release SHALL produce a pulse once debounced high.

Structure
REQ-031 Package alarm_pkg SHALL hold the edit and ring state encodings and the BCD limits (HOUR_MAX = 11, MIN_MAX = 59).
REQ-032 Sub-module btn_pulse (synchronizer, debounce, edge detect) SHALL be instantiated 3 times.
REQ-033 A competent implementation SHALL be about 200 RTL lines.

Verification
REQ-034 Press set once, inc 3x, set, inc 12x, set -> edit sequence 1,2,0; alarm 03:12.
REQ-035 In SET_H from 11, press inc -> 00. In SET_M from 59, press inc -> 00 with hour unchanged.
REQ-036 Alarm 01:05, arm = 1, time steps 01:04:59 -> 01:05:00 -> ringing = 1 next cycle; buzz toggles every 250 cycles; ringing = 0 after 60000 cycles.
REQ-037 While ringing, press btn_stop (10-cycle latency) -> ringing = 0, buzz = 0.
REQ-038 With time held at 01:05:00, no retrigger; arm = 0 at match -> no ring.
REQ-039 Assert rst mid-RING -> outputs at reset values before the next kclk edge.
REQ-040 A 3-cycle glitch on btn_inc -> no change.
